gpsreceiver3_rx: RTL and testbench

Parametrised GPS IF-sample capture engine for the next-generation GPS receiver core. It takes sign/magnitude samples, already synchronised into the system clock domain as one-cycle strobes, and packs them into memory words. It writes those words into a two-bank ping-pong buffer and hands each full bank to the CPU with an interrupt. It sits between the front-end synchroniser and the Wishbone-visible sample RAM, and its status feeds the CSR control interface.

---
 rtl/gpsreceiver3_rx.sv | 202 ++++++++++++++++++++
 tb/tb_gpsreceiver3_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpsreceiver3_rx.sv
// GPS IF-sample capture: packs sign/magnitude strobes into words and fills a two-bank ping-pong RAM.
// Optional build macro GPSRECEIVER3_SYNC_ALIGN_EN adds a WAIT_SYNC state so capture starts on an epoch marker.
module gpsreceiver3_rx #(
  parameter int SAMPLE_BITS = 2,
  parameter int WORD_BITS   = 32,
  parameter int DEPTH_LOG2  = 9
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  enable,
  input  logic                  smp_stb,
  input  logic                  smp_sign,
  input  logic                  smp_mag,
  input  logic                  smp_sync,
  input  logic [1:0]            bank_release,
  output logic [DEPTH_LOG2:0]   buf_adr,
  output logic [WORD_BITS-1:0]  buf_dat,
  output logic                  buf_we,
  output logic [1:0]            bank_full,
  output logic                  irq,
  output logic                  overrun,
  output logic [15:0]           word_count,
  output logic                  gps_led,
  output logic [1:0]            dbg_state
);
  localparam int K     = WORD_BITS / SAMPLE_BITS;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_STALL     = 2'd2
`ifdef GPSRECEIVER3_SYNC_ALIGN_EN
    , ST_WAIT_SYNC = 2'd3
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic                   bank_q, bank_d;
  logic [DEPTH_LOG2-1:0]  adr_q, adr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic [DEPTH_LOG2:0]    buf_adr_q, buf_adr_d;
  logic [WORD_BITS-1:0]   buf_dat_q, buf_dat_d;
  logic                   buf_we_q, buf_we_d;
  logic [1:0]             bank_full_q, bank_full_d;
  logic                   irq_q, irq_d;
  logic                   overrun_q, overrun_d;
  logic [15:0]            word_count_q, word_count_d;
  logic                   gps_led_q, gps_led_d;

  logic [SAMPLE_BITS-1:0] smp;
  logic [WORD_BITS-1:0]   shift_in;
  logic [1:0]             rel_mask;
  logic [1:0]             full_rel;
  logic                   other_bank;

  if (SAMPLE_BITS == 2) begin : g_sign_mag
    assign smp = {smp_sign, smp_mag};
  end else begin : g_sign_only
    logic unused_mag;
    assign smp        = smp_sign;
    assign unused_mag = smp_mag;
  end

`ifndef GPSRECEIVER3_SYNC_ALIGN_EN
  logic unused_sync;
  assign unused_sync = smp_sync;
`endif

  // New samples enter at the top so that sample 0 ends up in the low field.
  assign shift_in   = {smp, shift_q[WORD_BITS-1:SAMPLE_BITS]};
  assign other_bank = ~bank_q;

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    adr_d        = adr_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    buf_adr_d    = buf_adr_q;
    buf_dat_d    = buf_dat_q;
    buf_we_d     = 1'b0;
    bank_full_d  = bank_full_q;
    irq_d        = 1'b0;
    overrun_d    = overrun_q;
    word_count_d = word_count_q;
    gps_led_d    = gps_led_q;
    // Releases land before any completion this cycle; the bank being filled cannot be released.
    rel_mask = bank_release;
    if (state_q == ST_CAPTURE) rel_mask[bank_q] = 1'b0;
    full_rel = bank_full_q & ~rel_mask;

    if (!enable) begin
      state_d     = ST_IDLE;
      bank_d      = 1'b0;
      adr_d       = '0;
      cnt_d       = '0;
      bank_full_d = 2'b00;
      overrun_d   = 1'b0;
    end else begin
      bank_full_d = full_rel;
      case (state_q)
        ST_IDLE: begin
`ifdef GPSRECEIVER3_SYNC_ALIGN_EN
          state_d = ST_WAIT_SYNC;
`else
          state_d = ST_CAPTURE;
`endif
          bank_d = 1'b0;
          adr_d  = '0;
          cnt_d  = '0;
        end
`ifdef GPSRECEIVER3_SYNC_ALIGN_EN
        ST_WAIT_SYNC: begin
          if (smp_stb && smp_sync) begin
            shift_d = shift_in;
            cnt_d   = CNT_W'(1);
            state_d = ST_CAPTURE;
          end
        end
`endif
        ST_CAPTURE: begin
          if (smp_stb) begin
            shift_d = shift_in;
            if (cnt_q == CNT_W'(K - 1)) begin
              cnt_d        = '0;
              buf_we_d     = 1'b1;
              buf_adr_d    = {bank_q, adr_q};
              buf_dat_d    = shift_in;
              word_count_d = word_count_q + 16'd1;
              if (adr_q == '1) begin
                bank_full_d[bank_q] = 1'b1;
                irq_d               = 1'b1;
                gps_led_d           = ~gps_led_q;
                bank_d              = other_bank;
                adr_d               = '0;
                if (full_rel[other_bank]) state_d = ST_STALL;
              end else begin
                adr_d = adr_q + 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_STALL: begin
          // bank_q already points at the bank we are waiting to get back.
          if (smp_stb) overrun_d = 1'b1;
          if (bank_release[bank_q]) begin
            state_d = ST_CAPTURE;
            adr_d   = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      bank_q       <= 1'b0;
      adr_q        <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      buf_adr_q    <= '0;
      buf_dat_q    <= '0;
      buf_we_q     <= 1'b0;
      bank_full_q  <= 2'b00;
      irq_q        <= 1'b0;
      overrun_q    <= 1'b0;
      word_count_q <= 16'd0;
      gps_led_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      adr_q        <= adr_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      buf_adr_q    <= buf_adr_d;
      buf_dat_q    <= buf_dat_d;
      buf_we_q     <= buf_we_d;
      bank_full_q  <= bank_full_d;
      irq_q        <= irq_d;
      overrun_q    <= overrun_d;
      word_count_q <= word_count_d;
      gps_led_q    <= gps_led_d;
    end
  end

  assign buf_adr    = buf_adr_q;
  assign buf_dat    = buf_dat_q;
  assign buf_we     = buf_we_q;
  assign bank_full  = bank_full_q;
  assign irq        = irq_q;
  assign overrun    = overrun_q;
  assign word_count = word_count_q;
  assign gps_led    = gps_led_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_gpsreceiver3_rx.sv
// Bench for gpsreceiver3_rx: directed scenarios plus random traffic against a sample-stream reference model.
`timescale 1ns/1ps
module tb_gpsreceiver3_rx;
  localparam int SB = 2, WB = 8, DL = 2;
  localparam int K = WB / SB, WPB = 1 << DL;
  localparam int EXP_W = 3 + 8 + 1 + 2 + 16 + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, stb = 1'b0, sgn = 1'b0, mag = 1'b0, sync = 1'b0;
  logic [1:0] rel = 2'b00;
  logic [DL:0] buf_adr;
  logic [WB-1:0] buf_dat;
  logic buf_we, irq, overrun, gps_led;
  logic [1:0] bank_full, dbg_state;
  logic [15:0] word_count;

  gpsreceiver3_rx #(.SAMPLE_BITS(SB), .WORD_BITS(WB), .DEPTH_LOG2(DL)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .enable(en), .smp_stb(stb), .smp_sign(sgn),
    .smp_mag(mag), .smp_sync(sync), .bank_release(rel), .buf_adr(buf_adr),
    .buf_dat(buf_dat), .buf_we(buf_we), .bank_full(bank_full), .irq(irq),
    .overrun(overrun), .word_count(word_count), .gps_led(gps_led), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [WB-1:0] last_dat = '0;
  bit en_lvl = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the sample stream per bank, not the RTL's registers.
  typedef enum int {M_IDLE, M_WAIT, M_CAP, M_STALL} mode_t;
  mode_t m_mode = M_IDLE;
  int m_bank = 0, m_widx = 0, m_wc = 0;
  int part[$];
  bit [1:0] m_full = 2'b00;
  bit m_ovr = 1'b0, m_led = 1'b0;

  task automatic model_step(input bit e, input bit s, input logic [1:0] v, input bit sy, input logic [1:0] r);
    int dat, adr;
    bit irqv;
    if (!e) begin
      m_mode = M_IDLE; part.delete(); m_full = 2'b00; m_ovr = 1'b0;
      return;
    end
    if (m_mode == M_IDLE) begin
`ifdef GPSRECEIVER3_SYNC_ALIGN_EN
      m_mode = M_WAIT;
`else
      m_mode = M_CAP;
`endif
      m_bank = 0; m_widx = 0; part.delete();
      return;
    end
    for (int b = 0; b < 2; b++)
      if (r[b] && !(m_mode == M_CAP && b == m_bank)) m_full[b] = 1'b0;
    if (m_mode == M_STALL) begin
      if (s) m_ovr = 1'b1;
      if (r[m_bank]) begin m_mode = M_CAP; m_widx = 0; part.delete(); end
    end else if (m_mode == M_WAIT) begin
      if (s && sy) begin part.push_back(int'(v)); m_mode = M_CAP; end
    end else if (s) begin
      part.push_back(int'(v));
      if (part.size() == K) begin
        dat = 0;
        for (int i = 0; i < K; i++) dat += part[i] << (SB * i);
        part.delete();
        adr = m_bank * WPB + m_widx;
        m_wc = (m_wc + 1) % 65536;
        irqv = 1'b0;
        if (m_widx == WPB - 1) begin
          m_full[m_bank] = 1'b1; irqv = 1'b1; m_led = ~m_led;
          m_bank = 1 - m_bank; m_widx = 0;
          if (m_full[m_bank]) m_mode = M_STALL;
        end else begin
          m_widx++;
        end
        exp_q.push_back({3'(adr), 8'(dat), irqv, m_full, 16'(m_wc), m_led});
      end
    end
  endtask

  // One clock of stimulus; the visible state is compared with the model before the new inputs apply.
  task automatic drive(input bit s, input logic [1:0] v, input bit sy, input logic [1:0] r);
    @(posedge clk); #1;
    check("bank_full", bank_full, m_full);
    check("overrun", overrun, m_ovr);
    check("gps_led", gps_led, m_led);
    check("word_count", word_count, m_wc);
    en = en_lvl; stb = s; sgn = v[1]; mag = v[0]; sync = sy; rel = r;
    model_step(en_lvl, s, v, sy, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic strobes(input int n, input bit first_sync);
    for (int i = 0; i < n; i++)
      drive(1'b1, 2'($urandom_range(0, 3)), first_sync && i == 0, 2'b00);
  endtask

  // Monitor: every write is popped against the scoreboard.
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && buf_we) begin
        last_dat = buf_dat;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: adr=%0h dat=%0h, expected no write at %0t", buf_adr, buf_dat, $time);
        end else begin
          e = exp_q.pop_front();
          check("wr_adr", buf_adr, e[30:28]);
          check("wr_dat", buf_dat, e[27:20]);
          check("wr_irq", irq, e[19]);
          check("wr_bank_full", bank_full, e[18:17]);
          check("wr_word_count", word_count, e[16:1]);
          check("wr_gps_led", gps_led, e[0]);
        end
      end else if (rst_n && irq) begin
        checks++; errors++;
        $display("FAIL irq_without_write: irq=%0b, expected 0 at %0t", irq, $time);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_buf_adr", buf_adr, 0);
    check("rst_buf_dat", buf_dat, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_irq", irq, 0);
    check("rst_overrun", overrun, 0);
    check("rst_word_count", word_count, 0);
    check("rst_gps_led", gps_led, 0);
    rst_n = 1'b1;

    en_lvl = 1'b1;
    idle(1);
    drive(1'b1, 2'b01, 1'b1, 2'b00);
    drive(1'b1, 2'b10, 1'b0, 2'b00);
    drive(1'b1, 2'b11, 1'b0, 2'b00);
    drive(1'b1, 2'b00, 1'b0, 2'b00);
    idle(2);
    check("pack_dat", last_dat, 8'h39);
    check("pack_wc", word_count, 1);

    strobes(12, 1'b0);
    strobes(4, 1'b0);
    idle(2);
    check("switch_full", bank_full, 2'b01);
    check("switch_led", gps_led, 1);
    check("switch_irq_low", irq, 0);

    strobes(12, 1'b0);
    strobes(8, 1'b0);
    idle(2);
    check("stall_full", bank_full, 2'b11);
    check("stall_overrun", overrun, 1);
    check("stall_wc", word_count, 8);
    drive(1'b0, 2'b00, 1'b0, 2'b01);
    strobes(4, 1'b0);
    idle(2);
    check("resume_wc", word_count, 9);

    en_lvl = 1'b0;
    idle(1);
    en_lvl = 1'b1;
    idle(2);
    check("dis_full", bank_full, 2'b00);
    check("dis_overrun", overrun, 0);
    check("dis_wc", word_count, 9);
    check("dis_led", gps_led, 0);

    strobes(16, 1'b1);
    strobes(7, 1'b0);
    drive(1'b1, 2'b11, 1'b0, 2'b01);
    strobes(8, 1'b0);
    strobes(15, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 2'b10);
    strobes(4, 1'b0);
    idle(2);
    check("simul_full", bank_full, 2'b01);
    check("simul_overrun", overrun, 0);
    check("simul_wc", word_count, 22);

    strobes(2, 1'b0);
    en_lvl = 1'b0;
    idle(1);
    en_lvl = 1'b1;
    drive(1'b1, 2'b11, 1'b1, 2'b00);
    drive(1'b1, 2'b10, 1'b1, 2'b00);
    drive(1'b1, 2'b01, 1'b0, 2'b00);
    drive(1'b1, 2'b00, 1'b0, 2'b00);
    drive(1'b1, 2'b11, 1'b0, 2'b00);
    idle(2);
    check("midword_dat", last_dat, 8'hC6);
    check("midword_wc", word_count, 23);

`ifdef GPSRECEIVER3_SYNC_ALIGN_EN
    en_lvl = 1'b0;
    idle(1);
    en_lvl = 1'b1;
    idle(1);
    strobes(3, 1'b0);
    drive(1'b1, 2'b10, 1'b1, 2'b00);
    strobes(3, 1'b0);
    idle(2);
    check("sync_wc", word_count, 24);
    check("sync_lsb", last_dat[1:0], 2'b10);
`endif

    for (int i = 0; i < 600; i++) begin
      if (en_lvl && $urandom_range(0, 199) == 0) en_lvl = 1'b0;
      else if (!en_lvl && $urandom_range(0, 2) == 0) en_lvl = 1'b1;
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
            {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0});
    end
    idle(4);
    check("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
